// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC router constants and width helper
package noc_pkg;

    localparam int FLIT_W       = 8;
    localparam int FIFO_DEPTH   = 8;
    // Router derives each port's almost_full threshold as depth minus this margin
    localparam int AFULL_MARGIN = 2;

    // Smallest r with 2**r >= v; usable in constant expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// rtl/noc_fifo_mem.sv - DEPTHxDATA_W dual-port register array, sync write, registered read
// Ports: clk, rst (clears only the read register), wr_en/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (holds when rd_en=0)
module noc_fifo_mem
    import noc_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = FIFO_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is intentionally never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read/write returns the old word (only happens when full)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/noc_port_fifo.sv
// rtl/noc_port_fifo.sv - NoC router input-port flit FIFO with status and sticky error flags
// Ports: clk, rst (sync, active-high); write/data_in enqueue; read dequeue;
//        data_out/rd_valid registered head flit one cycle after an accepted read;
//        count/full/empty/almost_full occupancy status; overflow/underflow sticky
//        errors cleared by clr_err
module noc_port_fifo
    import noc_pkg::*;
#(
    parameter int DATA_W   = FLIT_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AFULL_TH = DEPTH - AFULL_MARGIN,
    localparam int CNT_W   = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int PTR_W = clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    // Status decoded straight from the registered count: no lag behind count
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign almost_full = (count >= CNT_W'(AFULL_TH));

    // A write at full is only taken when a read frees the head slot this cycle.
    // No bypass: on empty, a coincident read is rejected.
    assign rd_acc = read & ~empty;
    assign wr_acc = write & (~full | rd_acc);

    noc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc & ~rst),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc & ~rst),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            // Pointers roll over naturally since DEPTH is a power of two
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_valid <= rd_acc;

            if (wr_acc && !rd_acc) begin
                count <= count + CNT_W'(1);
            end else if (rd_acc && !wr_acc) begin
                count <= count - CNT_W'(1);
            end

            // A new error event beats a coincident clear
            if (write && !wr_acc) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (read && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_noc_port_fifo.sv
// tb/tb_noc_port_fifo.sv - directed self-checking bench for noc_port_fifo
module tb_noc_port_fifo;

    logic       clk;
    logic       rst;
    logic       write;
    logic [7:0] data_in;
    logic       read;
    logic [7:0] data_out;
    logic       rd_valid;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int checks = 0;
    int errors = 0;

    noc_port_fifo #(
        .DATA_W   (8),
        .DEPTH    (8),
        .AFULL_TH (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write       (write),
        .data_in     (data_in),
        .read        (read),
        .data_out    (data_out),
        .rd_valid    (rd_valid),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then settle 1ns past the edge for sampling
    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        write   = w;
        data_in = d;
        read    = r;
        @(posedge clk);
        #1;
        write = 1'b0;
        read  = 1'b0;
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        end
    endtask

    initial begin
        logic [7:0] exp_q [8];

        rst = 1'b1; write = 1'b0; read = 1'b0; data_in = '0; clr_err = 1'b0;

        // 1. reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);

        // 2. fill then drain
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_afull", 32'(almost_full), (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill_full", 32'(full), 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("drain_rd_valid", 32'(rd_valid), 1);
            chk("drain_data", 32'(data_out), 32'(8'h11 * (i + 1)));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("idle_rd_valid", 32'(rd_valid), 0);
        chk("idle_hold", 32'(data_out), 32'h88);

        // 3. overflow at full
        fill8();
        cyc(1'b1, 8'h99, 1'b0);
        chk("ovf_count", 32'(count), 8);
        chk("ovf_flag", 32'(overflow), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("ovf_head", 32'(data_out), 32'h11);
        chk("ovf_sticky", 32'(overflow), 1);
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        chk("ovf_clear", 32'(overflow), 0);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
        end
        chk("ovf_last", 32'(data_out), 32'h88);
        chk("ovf_empty", 32'(empty), 1);

        // 4. simultaneous write/read at full
        fill8();
        cyc(1'b1, 8'hAA, 1'b1);
        chk("sim_count", 32'(count), 8);
        chk("sim_data", 32'(data_out), 32'h11);
        chk("sim_rd_valid", 32'(rd_valid), 1);
        chk("sim_no_ovf", 32'(overflow), 0);
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hAA};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("sim_drain", 32'(data_out), 32'(exp_q[i]));
        end
        chk("sim_empty", 32'(empty), 1);

        // 5. write + read while empty
        cyc(1'b1, 8'h5A, 1'b1);
        chk("emp_count", 32'(count), 1);
        chk("emp_rd_valid", 32'(rd_valid), 0);
        chk("emp_underflow", 32'(underflow), 1);
        cyc(1'b0, 8'h00, 1'b1);
        chk("emp_data", 32'(data_out), 32'h5A);
        chk("emp_count2", 32'(count), 0);
        // clear coinciding with a new underflow: set wins
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        chk("emp_set_wins", 32'(underflow), 1);
        cyc(1'b0, 8'h00, 1'b0);
        clr_err = 1'b0;
        chk("emp_clear", 32'(underflow), 0);

        // 6. wrap with interleaved traffic, then reset mid-stream
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h03, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 8'(8'h04 + i), 1'b1);
            chk("wrap_data", 32'(data_out), 32'(8'h01 + i));
            chk("wrap_count", 32'(count), 3);
        end
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b1, 8'h21, 1'b0);
        chk("pre_rst_count", 32'(count), 5);
        rst = 1'b1;
        cyc(1'b1, 8'hEE, 1'b0);
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_data", 32'(data_out), 0);
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("post_rst_data", 32'(data_out), 32'h3C);
        chk("post_rst_valid", 32'(rd_valid), 1);
        chk("post_rst_empty", 32'(empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_port_fifo.md
Name: noc_port_fifo

Overview:
Parametrised input-port flit buffer for the NoC router, the successor to the fixed 8x8 per-port FIFOs.
- Generalised in flit width, depth and almost-full threshold.
- Correct full/empty accounting, including simultaneous read/write at every occupancy.
- Adds explicit status outputs (count, full, empty, almost_full) for the switch allocator and upstream flow control.
- Adds sticky overflow/underflow error flags and a registered read-data valid strobe.
- One instance sits on each router input port between the link and the crossbar.

Parameters:
DATA_W, 8, flit width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH (1..DEPTH)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset; synchronous, active-high
write  in  1  write request; wr_data captured when accepted
data_in  in  DATA_W  flit to enqueue
read  in  1  read request
data_out  out  DATA_W  registered head flit, valid when rd_valid=1
rd_valid  out  1  one-cycle strobe: data_out updated by a read accepted last cycle
count  out  CNT_W  current occupancy 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
almost_full  out  1  count>=AFULL_TH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  clears overflow/underflow (synchronous, one cycle)

Behaviour:
- Reset (rst=1 at posedge clk, synchronous, active-high):
  - Pointers = 0, count = 0, data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Storage array is not cleared.
  - Reset overrides any concurrent read/write in that cycle.
  - Reset mid-stream discards all contents; empty=1 the next cycle.
- Flags full, empty and almost_full are combinational from the registered count. They are therefore valid in the same cycle as count, with no one-cycle lag.
- Write acceptance:
  - wr_acc = write & (~full | rd_acc).
  - A write at full is accepted only when a read is accepted in the same cycle.
- Read acceptance: rd_acc = read & ~empty.
- Empty + write + read: write accepted, read rejected; there is no bypass path, and underflow is set.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr <= wr_ptr+1, wrapping from DEPTH-1 to 0.
- On rd_acc: data_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, with the same wrap; rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds its value.
- Read latency: 1 cycle from the accepting edge to data_out/rd_valid.
- Count update:
  - +1 on wr_acc & ~rd_acc.
  - -1 on rd_acc & ~wr_acc.
  - Unchanged otherwise, including a simultaneous accept at full.
  - count never exceeds DEPTH and never goes below 0.
- Pointer width is log2(DEPTH); wrap is the natural binary roll-over.
- Error flags:
  - overflow <= 1 when write & ~wr_acc.
  - underflow <= 1 when read & empty.
  - Both hold until clr_err or rst.
  - If clr_err coincides with a new error event, set wins.
- Order preserved strictly FIFO. A rejected write does not alter storage, pointers or count.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W (default 8)
  - FIFO_DEPTH (default 8)
  - a clog2 function or macro used for CNT_W and pointer widths
  - AFULL_MARGIN (2), used by the router to derive AFULL_TH
- Natural sub-module: noc_fifo_mem, a simple dual-port DEPTHxDATA_W register array with synchronous write and registered read. The control logic (pointers, count, flags, errors) stays in noc_port_fifo.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles -> count=0, empty=1, full=0, rd_valid=0, data_out=0, overflow=underflow=0.
2. Fill/drain, DEPTH=8:
   - write 0x11..0x88 on 8 consecutive cycles -> count=8, full=1, almost_full=1 from count=6.
   - read 8 times -> data_out 0x11..0x88 in order, each with rd_valid one cycle after its read; empty=1 after the last.
3. Overflow: at full, write 0x99 with read=0 -> count stays 8, overflow=1, next read returns 0x11.
   - clr_err -> overflow=0.
4. Simultaneous at full: full with 0x11..0x88, write 0xAA & read same cycle -> both accepted, count=8, data_out=0x11.
   - Draining then yields 0x22..0x88 followed by 0xAA.
5. Empty edge: empty, write 0x5A & read same cycle -> count=1, rd_valid=0, underflow=1; next read -> data_out=0x5A.
6. Wrap and reset mid-stream:
   - 20 interleaved write/read pairs at count=3 confirm pointer wrap with no data loss.
   - Then assert rst with count=5 -> count=0, empty=1 next cycle; a subsequent write 0x3C then read returns 0x3C.
